// File: rtl/acs_step_sched.sv
// Step scheduler for a time-multiplexed bank of Viterbi BMC/ACS units.
// Optional normalization is enabled by defining ACS_STEP_NORM_EN.
module acs_step_sched #(
  parameter int unsigned NUM_STATES  = 64,
  parameter int unsigned NUM_UNITS   = 8,
  parameter int unsigned PM_W        = 8,
  parameter int unsigned NORM_THRESH = 128,
  parameter int unsigned STEP_W      = 16,
  localparam int unsigned G          = NUM_STATES / NUM_UNITS,
  localparam int unsigned GW         = (G > 1) ? $clog2(G) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  input  logic [1:0]        rx_pair_i,
  input  logic              frame_start_i,
  output logic [1:0]        bmc_rx_pair_o,
  output logic [GW-1:0]     grp_idx_o,
  output logic              pm_rd_en_o,
  output logic [GW-1:0]     wr_grp_idx_o,
  output logic              pm_wr_en_o,
  output logic              pm_bank_o,
  output logic              pm_init_o,
  input  logic [PM_W-1:0]   acs_min_in_i,
  output logic              norm_en_o,
  output logic [PM_W-1:0]   norm_val_o,
  output logic              step_done_o,
  output logic [STEP_W-1:0] step_cnt_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       grp_q, wr_grp_q;
  logic                wr_en_q, bank_q, init_q;
  logic [STEP_W-1:0]   cnt_q;
  logic [1:0]          pair_q;
  logic                rd_en, accept, last_grp;

  assign last_grp = (grp_q == GW'(G - 1));
  assign accept   = (state_q == StIdle) && rx_valid_i;

  always_comb begin
    state_d     = state_q;
    rd_en       = 1'b0;
    rx_ready_o  = 1'b0;
    step_done_o = 1'b0;
    busy_o      = 1'b1;
    unique case (state_q)
      StIdle: begin
        rx_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (rx_valid_i) state_d = StRun;
      end
      StRun: begin
        rd_en = 1'b1;
        if (last_grp) state_d = StDrain;
      end
      StDrain: state_d = StDone;
      StDone: begin
        step_done_o = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      grp_q    <= '0;
      wr_grp_q <= '0;
      wr_en_q  <= 1'b0;
      bank_q   <= 1'b0;
      init_q   <= 1'b0;
      cnt_q    <= '0;
      pair_q   <= '0;
    end else begin
      state_q  <= state_d;
      // One-cycle ACS latency: writes trail reads by exactly one register.
      wr_en_q  <= rd_en;
      wr_grp_q <= grp_q;
      if (accept) begin
        pair_q <= rx_pair_i;
        grp_q  <= '0;
        init_q <= frame_start_i;
        if (frame_start_i) begin
          cnt_q  <= '0;
          bank_q <= 1'b0;
        end
      end
      if (state_q == StRun && !last_grp) grp_q <= grp_q + GW'(1);
      if (state_q == StDone) begin
        bank_q <= ~bank_q;
        cnt_q  <= cnt_q + STEP_W'(1);
        init_q <= 1'b0;
      end
    end
  end

`ifdef ACS_STEP_NORM_EN
  logic [PM_W-1:0] min_q, norm_val_q;
  logic            norm_en_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min_q      <= '1;
      norm_en_q  <= 1'b0;
      norm_val_q <= '0;
    end else begin
      if (accept) begin
        min_q <= '1;
        if (frame_start_i) norm_en_q <= 1'b0;
      end
      if (wr_en_q && (acs_min_in_i < min_q)) min_q <= acs_min_in_i;
      if (state_q == StDone) begin
        if (32'(min_q) >= NORM_THRESH) begin
          norm_en_q  <= 1'b1;
          norm_val_q <= min_q;
        end else begin
          norm_en_q  <= 1'b0;
        end
      end
    end
  end

  assign norm_en_o  = norm_en_q;
  assign norm_val_o = norm_val_q;
`else
  logic unused_norm;
  assign unused_norm = ^{acs_min_in_i, 32'(NORM_THRESH)};
  assign norm_en_o   = 1'b0;
  assign norm_val_o  = '0;
`endif

  assign bmc_rx_pair_o = pair_q;
  assign grp_idx_o     = grp_q;
  assign pm_rd_en_o    = rd_en;
  assign wr_grp_idx_o  = wr_grp_q;
  assign pm_wr_en_o    = wr_en_q;
  assign pm_bank_o     = bank_q;
  assign pm_init_o     = init_q;
  assign step_cnt_o    = cnt_q;

endmodule

// File: tb/tb_acs_step_sched.sv
// Self-checking bench for acs_step_sched against a step-level reference model.
module tb_acs_step_sched;
  localparam int unsigned NS = 64, NU = 8, PMW = 8, THR = 128, SW = 16;
  localparam int unsigned G  = NS / NU;
  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;

  logic clk = 1'b0, rst = 1'b0;
  logic rx_valid = 1'b0, frame_start = 1'b0;
  logic [1:0] rx_pair = '0;
  logic [PMW-1:0] acs_min = '0;
  logic rx_ready, pm_rd_en, pm_wr_en, pm_bank, pm_init, norm_en, step_done, busy;
  logic [1:0] bmc_rx_pair;
  logic [GW-1:0] grp_idx, wr_grp_idx;
  logic [PMW-1:0] norm_val;
  logic [SW-1:0] step_cnt;

  int vectors = 0, miscompares = 0;

  // Reference model state, updated once per step.
  logic exp_bank = 0, exp_init = 0, exp_norm_en = 0;
  logic [PMW-1:0] exp_norm_val = '0;
  int unsigned exp_cnt = 0;

  always #5 clk = ~clk;

  acs_step_sched #(.NUM_STATES(NS), .NUM_UNITS(NU), .PM_W(PMW), .NORM_THRESH(THR),
                   .STEP_W(SW)) dut (
    .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .rx_pair_i(rx_pair), .frame_start_i(frame_start), .bmc_rx_pair_o(bmc_rx_pair),
    .grp_idx_o(grp_idx), .pm_rd_en_o(pm_rd_en), .wr_grp_idx_o(wr_grp_idx),
    .pm_wr_en_o(pm_wr_en), .pm_bank_o(pm_bank), .pm_init_o(pm_init),
    .acs_min_in_i(acs_min), .norm_en_o(norm_en), .norm_val_o(norm_val),
    .step_done_o(step_done), .step_cnt_o(step_cnt), .busy_o(busy)
  );

  task automatic model_reset();
    exp_bank = 0; exp_init = 0; exp_norm_en = 0; exp_norm_val = '0; exp_cnt = 0;
  endtask

  // One full trellis step; inputs are driven and outputs checked on the falling edge.
  task automatic do_step(input logic [1:0] pair, input logic fs, input logic keep_valid,
                         input logic toggle, input logic [PMW-1:0] mins [G],
                         output longint t_acc);
    int n;
    logic [PMW-1:0] mn;
    logic exp_rd, exp_wr;
    @(negedge clk);
    n = 0;
    while (rx_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    vectors++;
    if (rx_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL accept_ready: rx_ready=%b busy=%b, want 1 0", rx_ready, busy);
    end
    t_acc = $time;
    rx_valid = 1'b1; rx_pair = pair; frame_start = fs;
    if (fs) begin exp_cnt = 0; exp_bank = 0; exp_norm_en = 0; end
    exp_init = fs;
    mn = '1;
    for (int k = 1; k <= G + 2; k++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (!keep_valid) rx_valid = 1'b0;
      if (toggle) rx_pair = ~rx_pair;
      exp_rd = (k <= G);
      exp_wr = (k >= 2) && (k <= G + 1);
      vectors++;
      if (pm_rd_en !== exp_rd || (exp_rd && grp_idx !== GW'(k - 1))) begin
        miscompares++;
        $display("FAIL rd k=%0d: rd=%b grp=%0d, want %b %0d", k, pm_rd_en, grp_idx, exp_rd, k - 1);
      end
      vectors++;
      if (pm_wr_en !== exp_wr || (exp_wr && wr_grp_idx !== GW'(k - 2))) begin
        miscompares++;
        $display("FAIL wr k=%0d: wr=%b grp=%0d, want %b %0d", k, pm_wr_en, wr_grp_idx,
                 exp_wr, k - 2);
      end
      vectors++;
      if (step_done !== (k == G + 2) || busy !== 1'b1 || rx_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ctl k=%0d: done=%b busy=%b ready=%b, want %b 1 0", k, step_done, busy,
                 rx_ready, k == G + 2);
      end
      vectors++;
      if (bmc_rx_pair !== pair || pm_init !== exp_init || pm_bank !== exp_bank ||
          step_cnt !== SW'(exp_cnt)) begin
        miscompares++;
        $display("FAIL state k=%0d: pair=%b init=%b bank=%b cnt=%0d, want %b %b %b %0d", k,
                 bmc_rx_pair, pm_init, pm_bank, step_cnt, pair, exp_init, exp_bank, exp_cnt);
      end
      vectors++;
      if (norm_en !== exp_norm_en || norm_val !== exp_norm_val) begin
        miscompares++;
        $display("FAIL norm k=%0d: en=%b val=%0d, want %b %0d", k, norm_en, norm_val,
                 exp_norm_en, exp_norm_val);
      end
      if (exp_wr) begin
        acs_min = mins[k - 2];
        if (acs_min < mn) mn = acs_min;
      end else begin
        acs_min = PMW'($urandom);
      end
    end
    exp_bank = ~exp_bank;
    exp_cnt  = (exp_cnt + 1) % (1 << SW);
    exp_init = 0;
`ifdef ACS_STEP_NORM_EN
    if (mn >= THR) begin exp_norm_en = 1; exp_norm_val = mn; end
    else exp_norm_en = 0;
`endif
  endtask

  task automatic rand_mins(output logic [PMW-1:0] m [G]);
    for (int i = 0; i < G; i++) m[i] = PMW'($urandom);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    vectors++;
    if (rx_ready !== 1'b1 || busy !== 1'b0 || pm_rd_en !== 1'b0 || pm_wr_en !== 1'b0 ||
        step_done !== 1'b0 || pm_bank !== exp_bank || step_cnt !== SW'(exp_cnt)) begin
      miscompares++;
      $display("FAIL %s: rdy=%b busy=%b rd=%b wr=%b done=%b bank=%b cnt=%0d, want 1 0 0 0 0 %b %0d",
               name, rx_ready, busy, pm_rd_en, pm_wr_en, step_done, pm_bank, step_cnt,
               exp_bank, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    vectors++;
    if ({rx_ready, busy, pm_rd_en, pm_wr_en, step_done, norm_en, pm_init, pm_bank} !== 8'b1000_0000
        || step_cnt !== '0 || grp_idx !== '0 || wr_grp_idx !== '0 || norm_val !== '0 ||
        bmc_rx_pair !== 2'b00) begin
      miscompares++;
      $display("FAIL reset: rdy=%b busy=%b rd=%b wr=%b done=%b bank=%b cnt=%0d", rx_ready, busy,
               pm_rd_en, pm_wr_en, step_done, pm_bank, step_cnt);
    end
  endtask

  task automatic test_single_step();
    logic [PMW-1:0] m [G];
    longint t;
    rand_mins(m);
    do_step(2'b01, 1'b1, 1'b0, 1'b0, m, t);
    check_idle("single_after");
  endtask

  task automatic test_back_to_back();
    logic [PMW-1:0] m [G];
    longint t0, t1;
    rand_mins(m);
    do_step(2'($urandom), 1'b1, 1'b1, 1'b0, m, t0);
    for (int s = 0; s < 2; s++) begin
      rand_mins(m);
      do_step(2'($urandom), 1'b0, 1'b1, 1'b0, m, t1);
      vectors++;
      if (t1 - t0 != longint'((G + 3) * 10)) begin
        miscompares++;
        $display("FAIL b2b_spacing: %0d, want %0d", t1 - t0, (G + 3) * 10);
      end
      t0 = t1;
    end
    rx_valid = 1'b0;
    check_idle("b2b_after");
  endtask

  task automatic test_norm();
    logic [PMW-1:0] m [G];
    longint t;
    m = '{200, 150, 180, 210, 170, 250, 160, 199};
    do_step(2'b10, 1'b1, 1'b0, 1'b0, m, t);
    m = '{90, 140, 40, 77, 200, 255, 60, 130};
    do_step(2'b11, 1'b0, 1'b0, 1'b0, m, t);
    rand_mins(m);
    do_step(2'b00, 1'b0, 1'b0, 1'b0, m, t);
  endtask

  task automatic test_hold();
    logic [PMW-1:0] m [G];
    longint t;
    rand_mins(m);
    do_step(2'b10, 1'b0, 1'b1, 1'b1, m, t);
    rand_mins(m);
    do_step(2'b01, 1'b0, 1'b0, 1'b0, m, t);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rx_valid = 1'b1; rx_pair = 2'b11; frame_start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      rx_valid = 1'b0; frame_start = 1'b0;
      acs_min = PMW'($urandom);
    end
    vectors++;
    if (grp_idx !== GW'(4) || pm_rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_grp: grp=%0d rd=%b, want 4 1", grp_idx, pm_rd_en);
    end
    rst = 1'b1;
    model_reset();
    check_idle("reset_mid");
    rst = 1'b0;
    check_idle("reset_mid_idle");
  endtask

  task automatic test_random();
    logic [PMW-1:0] m [G];
    longint t;
    for (int s = 0; s < 6; s++) begin
      rand_mins(m);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < G; i++) m[i] = PMW'($urandom_range(THR, 255));
      end
      do_step(2'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'b0, m, t);
    end
    rx_valid = 1'b0;
    check_idle("random_after");
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_back_to_back();
    test_norm();
    test_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
